// File: rtl/snn_inference_sequencer_if.sv
// Host/config and layer-facing bus of the SNN inference sequencer.
// Latency: none; this file holds wires only.
// Backpressure: result_valid/result_ready handshake on the result side.
interface snn_inference_sequencer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int N_OUT      = 4,
  parameter int CNT_W      = 8,
  parameter int STEP_W     = 8
);
  localparam int WIN_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                     start;
  logic                     abort;
  logic [STEP_W-1:0]        num_steps;
  logic [N_OUT-1:0]         out_spikes;
  logic [NUM_LAYERS-1:0]    layer_enable;
  logic                     net_clear;
  logic                     data_ready;
  logic                     busy;
  logic                     result_valid;
  logic                     result_ready;
  logic [WIN_W-1:0]         winner;
  logic [CNT_W-1:0]         winner_count;
  logic [N_OUT*CNT_W-1:0]   spike_counts;

  // Host / network side: issues commands, supplies spikes, consumes results.
  modport master (
    output start, abort, num_steps, out_spikes, result_ready,
    input  layer_enable, net_clear, data_ready, busy, result_valid,
    input  winner, winner_count, spike_counts
  );

  // Sequencer side.
  modport slave (
    input  start, abort, num_steps, out_spikes, result_ready,
    output layer_enable, net_clear, data_ready, busy, result_valid,
    output winner, winner_count, spike_counts
  );
endinterface

// File: rtl/snn_inference_sequencer.sv
// Run controller: clears the net, enables a skewed layer chain for S steps, counts output spikes, picks the winner.
// Latency: result_valid rises 2+S+NUM_LAYERS+N_OUT cycles after the accepted start.
// Backpressure: result and counts are held in DONE until result_ready; abort drops everything.
module snn_inference_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int N_OUT      = 4,
  parameter int CNT_W      = 8,
  parameter int STEP_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  snn_inference_sequencer_if.slave    bus
);

  localparam int WIN_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int DRN_W = $clog2(NUM_LAYERS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_SCAN, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;       // RUN cycles still to go
  logic [DRN_W-1:0]      drain_q, drain_d;     // DRAIN cycles elapsed
  logic [WIN_W-1:0]      idx_q, idx_d;         // class under scan
  logic [NUM_LAYERS-1:0] pipe_q, pipe_d;       // registered copy of each layer enable
  logic [CNT_W-1:0]      cnt_q [N_OUT];
  logic [CNT_W-1:0]      cnt_d [N_OUT];
  logic [WIN_W-1:0]      win_q, win_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;

  logic [NUM_LAYERS-1:0] layer_en;
  logic                  accept;
  logic                  sample;

  // Start is only taken in IDLE with a non-zero step count, and abort always beats it.
  assign accept = (state_q == S_IDLE) && bus.start && !bus.abort && (bus.num_steps != '0);
  // Final-layer spikes line up with the enable of the last layer delayed one more cycle.
  assign sample = pipe_q[NUM_LAYERS-1];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; DRAIN lasts NUM_LAYERS cycles so the last sample is counted before SCAN.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (accept) state_d = S_CLEAR;
        S_CLEAR: state_d = S_RUN;
        S_RUN:   if (step_q == STEP_W'(1)) state_d = S_DRAIN;
        S_DRAIN: if (drain_q == DRN_W'(NUM_LAYERS - 1)) state_d = S_SCAN;
        S_SCAN:  if (idx_q == WIN_W'(N_OUT - 1)) state_d = S_DONE;
        S_DONE:  if (bus.result_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state and the enable skew pipeline.
  always_comb begin
    layer_en    = '0;
    layer_en[0] = (state_q == S_RUN);
    for (int k = 1; k < NUM_LAYERS; k++) layer_en[k] = pipe_q[k-1];
    bus.layer_enable = layer_en;
    bus.net_clear    = (state_q == S_CLEAR);
    bus.data_ready   = sample;
    bus.busy         = (state_q != S_IDLE);
    bus.result_valid = (state_q == S_DONE);
    bus.winner       = win_q;
    bus.winner_count = wcnt_q;
    bus.spike_counts = '0;
    for (int i = 0; i < N_OUT; i++) bus.spike_counts[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  // Datapath next values: step/drain/scan counters, saturating class counters, running max.
  always_comb begin
    step_d  = step_q;
    drain_d = drain_q;
    idx_d   = idx_q;
    win_d   = win_q;
    wcnt_d  = wcnt_q;
    pipe_d  = bus.abort ? '0 : layer_en;
    for (int i = 0; i < N_OUT; i++) cnt_d[i] = cnt_q[i];

    if (bus.abort) begin
      step_d = '0;
      for (int i = 0; i < N_OUT; i++) cnt_d[i] = '0;
    end else begin
      if (accept) begin
        step_d  = bus.num_steps;
        drain_d = '0;
        idx_d   = '0;
        for (int i = 0; i < N_OUT; i++) cnt_d[i] = '0;
      end
      if (state_q == S_RUN)   step_d  = step_q - STEP_W'(1);
      if (state_q == S_DRAIN) drain_d = drain_q + DRN_W'(1);
      if (state_q == S_SCAN) begin
        idx_d = idx_q + WIN_W'(1);
        // Class 0 seeds the max; later classes replace it only when strictly larger.
        if ((idx_q == '0) || (cnt_q[idx_q] > wcnt_q)) begin
          win_d  = idx_q;
          wcnt_d = cnt_q[idx_q];
        end
      end
      if (sample) begin
        for (int i = 0; i < N_OUT; i++) begin
          if (bus.out_spikes[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q  <= '0;
      drain_q <= '0;
      idx_q   <= '0;
      pipe_q  <= '0;
      win_q   <= '0;
      wcnt_q  <= '0;
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
    end else begin
      step_q  <= step_d;
      drain_q <= drain_d;
      idx_q   <= idx_d;
      pipe_q  <= pipe_d;
      win_q   <= win_d;
      wcnt_q  <= wcnt_d;
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
